// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: latches an up-to-WIDTH-bit pattern and sends it MSB-first on w,
// repeated reps times back-to-back, with a start/busy/done handshake and stop abort.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LEN_W-1:0] LMAX = LEN_W'(WIDTH);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] pat, pat_n;
    logic [IW-1:0] i, i_n, lm1, lm1_n;
    logic [REP_W-1:0] r, r_n;
    logic [LEN_W-1:0] len_eff;
    logic load, last, w_n, w_valid_n, busy_n, done_n;
    assign len_eff = (len == '0 || len > LMAX) ? LMAX : len;
    assign load = state != SEND && start && !stop;
    assign last = i == '0 && r == REP_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pat <= '0;
            i <= '0;
            lm1 <= '0;
            r <= '0;
            w <= 1'b0;
            w_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            pat <= pat_n;
            i <= i_n;
            lm1 <= lm1_n;
            r <= r_n;
            w <= w_n;
            w_valid <= w_valid_n;
            busy <= busy_n;
            done <= done_n;
        end
    end
    // stop outranks both the normal SEND advance and a start seen in IDLE/DONE
    always_comb begin
        state_n = (state == SEND) ? (stop ? IDLE : (last ? DONE : SEND)) : (load ? SEND : IDLE);
        pat_n = load ? pattern : pat;
        lm1_n = load ? IW'(len_eff - LEN_W'(1)) : lm1;
        i_n = load ? IW'(len_eff - LEN_W'(1)) : (state == SEND) ? ((i != '0) ? i - IW'(1) : lm1) : i;
        r_n = load ? ((reps == '0) ? REP_W'(1) : reps) :
              (state == SEND && i == '0 && r != REP_W'(1)) ? r - REP_W'(1) : r;
    end
    // outputs are registered from the next-state view so the first bit follows start by one cycle
    always_comb begin
        w_n = (state_n == SEND) && pat_n[i_n];
        w_valid_n = state_n == SEND;
        busy_n = state_n == SEND;
        done_n = state_n == DONE;
    end
endmodule
